// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits, txd registered.
// Start bit appears 1 clk after valid&&ready; ready is low for the whole frame, so valid is simply held off.
module uart_tx_frame #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 txd,
  output logic                 busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  localparam logic [15:0] DIV_M1    = 16'(CLK_DIV - 1);
  localparam logic [3:0]  LAST_IDX  = 4'(DATA_BITS - 1);
  localparam logic        ACC_INIT  = (PARITY == 1);
  localparam logic        STOP_LAST = (STOP_BITS == 2);

  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_div
    $error("uart_tx_frame: CLK_DIV must be in 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end

  logic [2:0]           state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 acc_q, acc_d;
  logic                 stop_q, stop_d;
  logic                 txd_q, txd_d;
  logic                 boundary;

  assign ready    = (state_q == S_IDLE) && !rst;
  assign busy     = (state_q != S_IDLE);
  assign txd      = txd_q;
  assign boundary = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    stop_d  = stop_q;
    txd_d   = txd_q;

    // Every active bit reloads the period counter at its boundary.
    if (state_q != S_IDLE) begin
      cnt_d = boundary ? DIV_M1 : cnt_q - 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        cnt_d = 16'd0;
        if (valid && ready) begin
          shift_d = data;
          acc_d   = ACC_INIT;
          state_d = S_START;
          txd_d   = 1'b0;
          cnt_d   = DIV_M1;
        end
      end
      S_START: begin
        if (boundary) begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          acc_d   = acc_q ^ shift_q[0];
          idx_d   = 4'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (boundary) begin
          if (idx_q < LAST_IDX) begin
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
            acc_d   = acc_q ^ shift_q[0];
            idx_d   = idx_q + 4'd1;
          end else if (PARITY != 0) begin
            txd_d   = acc_q;
            state_d = S_PAR;
          end else begin
            txd_d   = 1'b1;
            stop_d  = 1'b0;
            state_d = S_STOP;
          end
        end
      end
      S_PAR: begin
        if (boundary) begin
          txd_d   = 1'b1;
          stop_d  = 1'b0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (boundary) begin
          txd_d = 1'b1;
          if (stop_q == STOP_LAST) begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 4'd0;
      shift_q <= '0;
      acc_q   <= 1'b0;
      stop_q  <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      stop_q  <= stop_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations (8N1, 8E1, 8O1 at /4, 7N2 at /3) against a frame-level model.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [8:0] din     [4];
  logic       valid_r [4];
  logic       ready_w [4];
  logic       txd_w   [4];
  logic       busy_w  [4];

  int div_c [4] = '{4, 4, 4, 3};
  int nb_c  [4] = '{8, 8, 8, 7};
  int par_c [4] = '{0, 2, 1, 0};
  int sb_c  [4] = '{1, 1, 1, 2};

  int errors = 0;
  int checks = 0;

  uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .data(din[0][7:0]), .valid(valid_r[0]),
    .ready(ready_w[0]), .txd(txd_w[0]), .busy(busy_w[0]));
  uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .data(din[1][7:0]), .valid(valid_r[1]),
    .ready(ready_w[1]), .txd(txd_w[1]), .busy(busy_w[1]));
  uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .data(din[2][7:0]), .valid(valid_r[2]),
    .ready(ready_w[2]), .txd(txd_w[2]), .busy(busy_w[2]));
  uart_tx_frame #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .data(din[3][6:0]), .valid(valid_r[3]),
    .ready(ready_w[3]), .txd(txd_w[3]), .busy(busy_w[3]));

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int frame_len(input int i);
    return div_c[i] * (1 + nb_c[i] + ((par_c[i] != 0) ? 1 : 0) + sb_c[i]);
  endfunction

  // Line level of frame bit b: 0 = start, 1..nb = data LSB first, then parity, then stop bits.
  function automatic logic exp_bit(input int i, input logic [8:0] w, input int b);
    logic [8:0] m;
    int ones;
    m = w;
    for (int j = 0; j < 9; j++) if (j >= nb_c[i]) m[j] = 1'b0;
    ones = $countones(m);
    if (b == 0) return 1'b0;
    if (b <= nb_c[i]) return m[b-1];
    if (par_c[i] != 0 && b == nb_c[i] + 1)
      return (par_c[i] == 2) ? logic'(ones % 2) : logic'(1 - ones % 2);
    return 1'b1;
  endfunction

  task automatic run_frame(input int i, input logic [8:0] word, input bit keep_valid,
                           input logic [8:0] next_word, input int abort_at);
    int n = 0;
    int f = frame_len(i);
    while (!ready_w[i] && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", ready_w[i], 1'b1);
    din[i]     = word;
    valid_r[i] = 1'b1;
    @(negedge clk);
    if (!keep_valid) valid_r[i] = 1'b0;
    din[i] = next_word;
    for (int k = 0; k < f; k++) begin
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check("abort_txd", txd_w[i], 1'b1);
        check("abort_busy", busy_w[i], 1'b0);
        check("abort_ready", ready_w[i], 1'b0);
        rst        = 1'b0;
        valid_r[i] = 1'b0;
        return;
      end
      check($sformatf("u%0d_txd_c%0d", i, k), txd_w[i], exp_bit(i, word, k / div_c[i]));
      check($sformatf("u%0d_busy_c%0d", i, k), busy_w[i], 1'b1);
      check($sformatf("u%0d_ready_c%0d", i, k), ready_w[i], 1'b0);
      @(negedge clk);
    end
    check($sformatf("u%0d_end_txd", i), txd_w[i], 1'b1);
    check($sformatf("u%0d_end_busy", i), busy_w[i], 1'b0);
    check($sformatf("u%0d_end_ready", i), ready_w[i], 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] w, w2;
    int i;
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      valid_r[j] = 1'b0;
      din[j]     = '0;
    end
    repeat (3) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        check("rst_txd", txd_w[j], 1'b1);
        check("rst_busy", busy_w[j], 1'b0);
        check("rst_ready", ready_w[j], 1'b0);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      check("post_rst_ready", ready_w[j], 1'b1);
      check("post_rst_txd", txd_w[j], 1'b1);
    end

    run_frame(0, 9'h0A5, 1'b0, 9'($urandom), -1);
    run_frame(1, 9'h0A5, 1'b0, 9'($urandom), -1);
    run_frame(2, 9'h0A5, 1'b0, 9'($urandom), -1);
    run_frame(3, 9'h07F, 1'b0, 9'($urandom), -1);

    // valid held high: second word follows after exactly one idle-high cycle
    run_frame(0, 9'h055, 1'b1, 9'h00F, -1);
    run_frame(0, 9'h00F, 1'b0, 9'($urandom), -1);

    // reset during the third data bit, then a fresh frame two cycles later
    run_frame(0, 9'($urandom), 1'b0, 9'($urandom), 3 * 4 + 1);
    @(negedge clk);
    run_frame(0, 9'($urandom), 1'b0, 9'($urandom), -1);

    for (int it = 0; it < 24; it++) begin
      i  = int'($urandom_range(0, 3));
      w  = 9'($urandom);
      w2 = 9'($urandom);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check("gap_txd", txd_w[i], 1'b1);
        check("gap_busy", busy_w[i], 1'b0);
      end
      if ($urandom_range(0, 1) == 1) begin
        run_frame(i, w, 1'b1, w2, -1);
        run_frame(i, w2, 1'b0, 9'($urandom), -1);
      end else begin
        run_frame(i, w, 1'b0, w2, -1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
